switch_array: RTL and testbench

- Input-side counterpart of the LED output block. Samples an external array of switches/push-buttons and presents a clean, debounced, clock-synchronous word to the user design.
- Each bit is synchronized, debounced, and reports accepted changes through a one-cycle pulse and sticky per-bit event flags.
- Event flags are cleared by write-1-to-clear.
- Sits between the board pins and Synthesijer-generated logic, which polls `data` / `event_flags`.

---
 rtl/switch_array.sv | 99 +++++++++
 tb/tb_switch_array.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_array.sv
// switch_array: samples a bank of raw switch/push-button pins and presents a
// clean, clock-synchronous, debounced word. Each bit passes through a 2-FF
// synchronizer and a per-bit debounce counter clocked by a shared sample tick.
// Accepted changes raise a one-cycle "changed" pulse and set sticky per-bit
// event flags, which the user design clears by writing 1s to clear_flags.
module switch_array #(
   parameter int WIDTH          = 32,
   parameter int TICK_DIV       = 50000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ext_switch_array,
   output logic [WIDTH-1:0] data,
   output logic             changed,
   output logic [WIDTH-1:0] event_flags,
   input  logic [WIDTH-1:0] clear_flags
);

   // Prescaler counts 0..TICK_DIV-1; debounce counters must reach STABLE_SAMPLES-1.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_SAMPLES) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SAMPLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [PW-1:0]    prescaler;
   logic             tick;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] accept;

   // Two-stage synchronizer; only sync2 is trusted downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ext_switch_array;
         sync2 <= sync1;
      end
   end

   // Free-running sample prescaler, wraps after TICK_DIV cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // One-cycle sample strobe, decoded straight from the prescaler value.
   assign tick = (prescaler == PRESC_LAST);

   // A bit is accepted on the tick that completes its run of differing samples.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = tick && (sync2[i] != data[i]) && (cnt[i] == CNT_LAST);
      end
   end

   // Per-bit run-length counters; any agreeing sample restarts the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else if (tick) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == data[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Registered outputs: accepted bits flip data, pulse changed, and set flags
   // (a set on the same cycle as a clear wins).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data        <= '0;
         changed     <= 1'b0;
         event_flags <= '0;
      end else begin
         data        <= data ^ accept;
         changed     <= |accept;
         event_flags <= (event_flags & ~clear_flags) | accept;
      end
   end

endmodule

// File: tb/tb_switch_array.sv
// Bench for switch_array with TICK_DIV=4, STABLE_SAMPLES=3. A reference model
// tracks the last STABLE_SAMPLES tick samples of each bit and accepts a change
// when all of them disagree with the current debounced value.
module tb_switch_array;
   localparam int W  = 32;
   localparam int TD = 4;
   localparam int SS = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] ext = '0;
   logic [W-1:0] clear = '0;
   logic [W-1:0] data;
   logic         changed;
   logic [W-1:0] flags;

   int checks = 0;
   int errors = 0;

   switch_array #(.WIDTH(W), .TICK_DIV(TD), .STABLE_SAMPLES(SS)) dut (
      .clk              (clk),
      .reset            (reset),
      .ext_switch_array (ext),
      .data             (data),
      .changed          (changed),
      .event_flags      (flags),
      .clear_flags      (clear)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // Reference model state.
   typedef struct packed {
      logic [W-1:0]         data;
      logic [W-1:0]         flags;
      logic                 changed;
      logic [W-1:0]         in_prev1;   // input seen one edge ago
      logic [W-1:0]         in_prev2;   // input seen two edges ago
      logic [SS-1:0][W-1:0] samples;    // most recent tick samples, [0] newest
      logic [31:0]          cyc;        // edges since reset release
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_next(mstate_t s, logic [W-1:0] in, logic [W-1:0] clr);
      mstate_t      n;
      logic [W-1:0] seen;
      logic [W-1:0] acc;
      n    = s;
      seen = s.in_prev2;
      n.in_prev2 = s.in_prev1;
      n.in_prev1 = in;
      acc = '0;
      if ((s.cyc % TD) == TD - 1) begin
         for (int k = SS - 1; k > 0; k--) n.samples[k] = s.samples[k-1];
         n.samples[0] = seen;
         acc = '1;
         for (int k = 0; k < SS; k++) acc &= (n.samples[k] ^ s.data);
      end
      n.cyc     = s.cyc + 1;
      n.changed = |acc;
      n.flags   = (s.flags & ~clr) | acc;
      n.data    = s.data ^ acc;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= '0;
      else       m <= model_next(m, ext, clear);
   end

   // Driver helper: pulse reset with the given pin value; returns on the
   // falling edge where reset is released.
   task automatic do_reset(input logic [W-1:0] v);
      @(negedge clk);
      reset = 1'b1;
      ext   = v;
      clear = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      int pulses;
      bit done;
      @(negedge clk);
      reset = 1'b1;
      ext   = '1;
      clear = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
      checks++;
      if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b want 0", changed); end
      checks++;
      if (flags !== '0) begin errors++; $display("FAIL reset_flags: got %h want 0", flags); end
      reset = 1'b0;
      lat = 0; pulses = 0; done = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         checks++;
         if ({data, changed, flags} !== {m.data, m.changed, m.flags}) begin
            errors++;
            $display("FAIL reset_model c=%0d: got %h/%b/%h want %h/%b/%h", c, data, changed, flags, m.data, m.changed, m.flags);
         end
         if (changed === 1'b1) pulses++;
         if (!done && data === '1) begin lat = c; done = 1; end
      end
      checks++;
      if (!done || lat < 11 || lat > 15) begin errors++; $display("FAIL reset_latency: got %0d (seen=%0d) want 11..15", lat, done); end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL reset_pulses: got %0d want 1", pulses); end
      checks++;
      if (flags !== '1) begin errors++; $display("FAIL reset_release_flags: got %h want ffffffff", flags); end
   endtask

   task automatic test_clean_edge();
      int lat;
      int pulses;
      bit done;
      do_reset('0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ext = 32'h1;
      lat = 0; pulses = 0; done = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         checks++;
         if ({data, changed, flags} !== {m.data, m.changed, m.flags}) begin
            errors++;
            $display("FAIL edge_model c=%0d: got %h/%b/%h want %h/%b/%h", c, data, changed, flags, m.data, m.changed, m.flags);
         end
         if (changed === 1'b1) pulses++;
         if (!done && data[0] === 1'b1) begin lat = c; done = 1; end
      end
      checks++;
      if (!done || lat < 11 || lat > 15) begin errors++; $display("FAIL edge_latency: got %0d (seen=%0d) want 11..15", lat, done); end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL edge_pulses: got %0d want 1", pulses); end
      checks++;
      if (flags !== 32'h1) begin errors++; $display("FAIL edge_flags: got %h want 00000001", flags); end
      checks++;
      if (data !== 32'h1) begin errors++; $display("FAIL edge_data: got %h want 00000001", data); end
   endtask

   task automatic test_glitch();
      int pulses;
      bit moved;
      do_reset('0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ext = 32'h8;
      pulses = 0; moved = 0;
      for (int c = 1; c <= 31; c++) begin
         @(negedge clk);
         if (c == 6) ext = '0;
         if (changed === 1'b1) pulses++;
         if (data !== '0) moved = 1;
      end
      checks++;
      if (moved) begin errors++; $display("FAIL glitch_data_moved: got 1 want 0 (final %h)", data); end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
      checks++;
      if (flags !== '0) begin errors++; $display("FAIL glitch_flags: got %h want 0", flags); end
   endtask

   task automatic test_w1c();
      do_reset('0);
      ext = 32'h1;
      repeat (16) @(negedge clk);
      checks++;
      if (flags !== 32'h1) begin errors++; $display("FAIL w1c_pre_flags: got %h want 00000001", flags); end
      clear = 32'h1;
      @(negedge clk);
      clear = '0;
      checks++;
      if (flags !== '0) begin errors++; $display("FAIL w1c_clear: got %h want 0", flags); end
      clear = 32'h1;
      @(negedge clk);
      clear = '0;
      checks++;
      if (flags !== '0) begin errors++; $display("FAIL w1c_reclear: got %h want 0", flags); end
      @(negedge clk);
      checks++;
      if (data !== 32'h1 || flags !== '0) begin errors++; $display("FAIL w1c_hold: got %h/%h want 00000001/0", data, flags); end
   endtask

   task automatic test_set_wins();
      bit done;
      do_reset('0);
      ext   = 32'h20;
      clear = 32'h20;
      done  = 0;
      for (int c = 1; c <= 30 && !done; c++) begin
         @(negedge clk);
         if (data[5] === 1'b1) done = 1;
      end
      checks++;
      if (!done || flags[5] !== 1'b1) begin errors++; $display("FAIL set_wins: got flag=%b (seen=%0d) want 1", flags[5], done); end
      @(negedge clk);
      clear = '0;
      checks++;
      if (flags !== '0) begin errors++; $display("FAIL set_then_clear: got %h want 0", flags); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit done;
      do_reset(32'h80);
      repeat (9) @(negedge clk);
      checks++;
      if (data !== '0) begin errors++; $display("FAIL mid_precount: got %h want 0", data); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (data !== '0 || flags !== '0) begin errors++; $display("FAIL mid_in_reset: got %h/%h want 0/0", data, flags); end
      reset = 1'b0;
      lat = 0; done = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (!done && data[7] === 1'b1) begin lat = c; done = 1; end
      end
      checks++;
      if (!done || lat != 12) begin errors++; $display("FAIL mid_latency: got %0d (seen=%0d) want 12", lat, done); end
      checks++;
      if (flags !== 32'h80) begin errors++; $display("FAIL mid_flags: got %h want 00000080", flags); end
   endtask

   task automatic test_multi();
      int lat;
      int pulses;
      bit done;
      bit partial;
      do_reset('0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ext = 32'h8000_0101;
      lat = 0; pulses = 0; done = 0; partial = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (changed === 1'b1) pulses++;
         if (data !== '0 && data !== 32'h8000_0101) partial = 1;
         if (!done && data === 32'h8000_0101) begin lat = c; done = 1; end
      end
      checks++;
      if (!done || lat < 11 || lat > 15 || partial) begin errors++; $display("FAIL multi_data: got %h lat=%0d partial=%0d want 80000101 in 11..15", data, lat, partial); end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL multi_pulses: got %0d want 1", pulses); end
      checks++;
      if (flags !== 32'h8000_0101) begin errors++; $display("FAIL multi_flags: got %h want 80000101", flags); end
   endtask

   task automatic test_random();
      do_reset('0);
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         checks++;
         if ({data, changed, flags} !== {m.data, m.changed, m.flags}) begin
            errors++;
            $display("FAIL random_model c=%0d: got %h/%b/%h want %h/%b/%h", c, data, changed, flags, m.data, m.changed, m.flags);
         end
         if (c == 400) reset = 1'b1;
         else          reset = 1'b0;
         if ($urandom_range(0, 5) == 0) ext = ext ^ (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) clear = $urandom & $urandom;
         else                           clear = '0;
      end
      clear = '0;
   endtask

   initial begin
      test_reset();
      test_clean_edge();
      test_glitch();
      test_w1c();
      test_set_wins();
      test_reset_mid();
      test_multi();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
